// File: rtl/mutex_client_4.sv
// mutex_client_4: four independent request/own/release clients for a 4-way
// arbiter, with hold and wait timers, timeout pulses and sticky grant errors.
module mutex_client_4 #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] start,
  output logic       X3,
  output logic       X2,
  output logic       X1,
  output logic       X0,
  input  logic       Y3,
  input  logic       Y2,
  input  logic       Y1,
  input  logic       Y0,
  output logic [3:0] busy,
  output logic [3:0] done,
  output logic [3:0] timeout,
  output logic       err_multi,
  output logic       err_spur
);

  localparam int unsigned NCH = 4;
  localparam int unsigned HW  = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_OWN, S_REL} state_t;

  state_t        r_state     [NCH];
  state_t        w_state_nxt [NCH];
  logic [HW-1:0] r_hold      [NCH];
  logic [HW-1:0] w_hold_nxt  [NCH];
  logic [TW-1:0] r_wait      [NCH];
  logic [TW-1:0] w_wait_nxt  [NCH];

  logic [3:0] r_x, r_busy, r_done, r_timeout;
  logic       r_err_multi, r_err_spur;
  logic [3:0] w_x_nxt, w_busy_nxt, w_done_nxt, w_timeout_nxt;
  logic       w_err_multi_nxt, w_err_spur_nxt;
  logic [3:0] w_y;

  assign w_y = {Y3, Y2, Y1, Y0};

  // State, counters and registered outputs; reset is asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= S_IDLE;
        r_hold[i]  <= '0;
        r_wait[i]  <= '0;
      end
      r_x         <= '0;
      r_busy      <= '0;
      r_done      <= '0;
      r_timeout   <= '0;
      r_err_multi <= 1'b0;
      r_err_spur  <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_hold[i]  <= w_hold_nxt[i];
        r_wait[i]  <= w_wait_nxt[i];
      end
      r_x         <= w_x_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_timeout   <= w_timeout_nxt;
      r_err_multi <= w_err_multi_nxt;
      r_err_spur  <= w_err_spur_nxt;
    end
  end

  // Per-channel next state; revoked grant in OWN takes priority over the hold count.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_hold_nxt[i]  = r_hold[i];
      w_wait_nxt[i]  = r_wait[i];
      case (r_state[i])
        S_IDLE: begin
          if (start[i]) begin
            w_state_nxt[i] = S_REQ;
            w_wait_nxt[i]  = '0;
          end
        end
        S_REQ: begin
          if (w_y[i]) begin
            w_state_nxt[i] = S_OWN;
            w_hold_nxt[i]  = HW'(HOLD_CYCLES - 1);
          end else if (r_wait[i] != TW'(TIMEOUT)) begin
            w_wait_nxt[i] = r_wait[i] + TW'(1);
          end
        end
        S_OWN: begin
          if (!w_y[i] || (r_hold[i] == '0)) begin
            w_state_nxt[i] = S_REL;
          end else begin
            w_hold_nxt[i] = r_hold[i] - HW'(1);
          end
        end
        S_REL: begin
          if (!w_y[i]) begin
            w_state_nxt[i] = S_IDLE;
          end
        end
        default: w_state_nxt[i] = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, decoded from current and next state.
  always_comb begin
    w_x_nxt         = '0;
    w_busy_nxt      = '0;
    w_done_nxt      = '0;
    w_timeout_nxt   = '0;
    w_err_spur_nxt  = r_err_spur;
    w_err_multi_nxt = r_err_multi | ((w_y & (w_y - 4'd1)) != 4'd0);
    for (int i = 0; i < NCH; i++) begin
      w_x_nxt[i]    = (w_state_nxt[i] == S_REQ) || (w_state_nxt[i] == S_OWN);
      w_busy_nxt[i] = (w_state_nxt[i] != S_IDLE);
      w_done_nxt[i] = (r_state[i] == S_REL) && (w_state_nxt[i] == S_IDLE);
      // Fires only on the step into TIMEOUT; saturation prevents a repeat.
      w_timeout_nxt[i] = (r_state[i] == S_REQ) && (r_wait[i] != TW'(TIMEOUT)) &&
                         (w_wait_nxt[i] == TW'(TIMEOUT));
      if (w_y[i] && (r_state[i] == S_IDLE)) begin
        w_err_spur_nxt = 1'b1;
      end
    end
  end

  assign X3        = r_x[3];
  assign X2        = r_x[2];
  assign X1        = r_x[1];
  assign X0        = r_x[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign err_multi = r_err_multi;
  assign err_spur  = r_err_spur;

endmodule

// File: tb/tb_mutex_client_4.sv
// Self-checking bench for mutex_client_4: a scoreboard of expected done and
// timeout pulses (channel and cycle) plus direct checks of levels and flags.
module tb_mutex_client_4;

  localparam int HOLD = 4;
  localparam int TMO  = 64;

  typedef struct {
    int kind;  // 0 = done, 1 = timeout
    int ch;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] start = '0;
  logic [3:0] y = '0;
  logic       X3, X2, X1, X0;
  logic [3:0] busy, done, tout;
  logic       err_multi, err_spur;
  logic [3:0] xv;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_own;
  int   s;
  ev_t  q[$];
  ev_t  mon_e;

  assign xv = {X3, X2, X1, X0};

  mutex_client_4 #(.HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .X3(X3), .X2(X2), .X1(X1), .X0(X0),
    .Y3(y[3]), .Y2(y[2]), .Y1(y[1]), .Y0(y[0]),
    .busy(busy), .done(done), .timeout(tout),
    .err_multi(err_multi), .err_spur(err_spur)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbiter model: grant ch after dly cycles, hold it until X drops, then release.
  task automatic serve(input int ch, input int dly, output int n);
    bit ended;
    for (int k = 0; k < dly; k++) tick();
    y[ch] = 1'b1;
    n = 0;
    ended = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (xv[ch]) n++;
      else begin
        ended = 1'b1;
        break;
      end
    end
    check("x_released", int'(ended), 1);
    check("hold_len", n, HOLD);
    y[ch] = 1'b0;
    q.push_back('{0, ch, cyc + 1});
  endtask

  // Monitor: every done/timeout pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < 2; k++) begin
          if ((k == 0 && done[i]) || (k == 1 && tout[i])) begin
            if (q.size() == 0) begin
              check("unexpected_pulse", int'(k == 0 ? done[i] : tout[i]), 0);
            end else begin
              mon_e = q.pop_front();
              check("ev_kind", k, mon_e.kind);
              check("ev_ch", i, mon_e.ch);
              check("ev_cyc", cyc, mon_e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst_x", int'(xv), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tout", int'(tout), 0);
    check("rst_emulti", int'(err_multi), 0);
    check("rst_espur", int'(err_spur), 0);
    rst_n = 1'b1;
    tick();

    // Single tenure on channel 0, grant 2 cycles after X0 rises
    start = 4'b0001;
    tick();
    start = 4'b0000;
    check("t1_x0_rise", int'(X0), 1);
    check("t1_busy", int'(busy), 1);
    tick();
    check("t1_x0_req", int'(X0), 1);
    serve(0, 0, n_own);
    tick();
    check("t1_done", int'(done), 1);
    check("t1_busy_clr", int'(busy[0]), 0);
    // Start during the done pulse is accepted
    start = 4'b0001;
    tick();
    start = 4'b0000;
    check("t1_restart", int'(X0), 1);
    serve(0, 1, n_own);
    tick(); tick();
    check("t1_espur", int'(err_spur), 0);

    // All four at once, serialized grants 3,2,1,0
    start = 4'b1111;
    tick();
    start = 4'b0000;
    check("t2_all_x", int'(xv), 15);
    check("t2_all_busy", int'(busy), 15);
    serve(3, 0, n_own);
    serve(2, 0, n_own);
    serve(1, 0, n_own);
    serve(0, 0, n_own);
    tick(); tick();
    check("t2_emulti", int'(err_multi), 0);
    check("t2_busy_clr", int'(busy), 0);

    // Timeout on channel 2 with no grant for 70 cycles
    s = cyc;
    start = 4'b0100;
    q.push_back('{1, 2, s + 1 + TMO});
    tick();
    start = 4'b0000;
    check("t3_x2_rise", int'(X2), 1);
    for (int k = 1; k < 70; k++) tick();
    check("t3_x2_held", int'(X2), 1);
    check("t3_busy2", int'(busy[2]), 1);
    serve(2, 0, n_own);
    tick(); tick();

    // Spurious grant on idle channel 2
    check("t4_espur_pre", int'(err_spur), 0);
    y = 4'b0100;
    tick();
    y = 4'b0000;
    check("t4_espur", int'(err_spur), 1);
    check("t4_x2_low", int'(X2), 0);
    check("t4_busy2", int'(busy[2]), 0);

    // Two grants in the same cycle
    check("t5_emulti_pre", int'(err_multi), 0);
    y = 4'b1010;
    tick();
    y = 4'b0000;
    check("t5_emulti", int'(err_multi), 1);
    tick(); tick(); tick();
    check("t5_emulti_sticky", int'(err_multi), 1);

    // Reset during OWN on channel 0
    start = 4'b0001;
    tick();
    start = 4'b0000;
    y[0] = 1'b1;
    tick(); tick();
    check("t6_x0_own", int'(X0), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_x0_async", int'(X0), 0);
    check("t6_busy_async", int'(busy), 0);
    check("t6_emulti_clr", int'(err_multi), 0);
    check("t6_espur_clr", int'(err_spur), 0);
    y[0] = 1'b0;
    tick(); tick();
    check("t6_no_done", int'(done), 0);
    rst_n = 1'b1;
    start = 4'b0001;
    tick();
    start = 4'b0000;
    check("t6_restart", int'(X0), 1);
    serve(0, 1, n_own);
    tick(); tick(); tick();
    check("queue_empty", q.size(), 0);
    check("end_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
